select_input_ctrl: RTL and testbench

Front-end controller that turns the four raw board pushbuttons into the cursor/colour command stream consumed by the LED-cube selection block. It produces the Pos, cCol, x, y, z and c signals, so the user can step through X, Y and Z, then colour, then commit a voxel. It synchronises, debounces, edge-detects and auto-repeats the buttons, and sequences the user through the fields with an FSM.

---
 rtl/select_pkg.sv | 43 ++++
 rtl/key_debounce.sv | 87 ++++++++
 rtl/select_input_ctrl.sv | 127 ++++++++++++
 tb/tb_select_input_ctrl.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/select_pkg.sv
// Shared types and constants for the pushbutton selection front end.
package select_pkg;

   localparam int unsigned COORD_W = 3;
   localparam int unsigned COLOR_W = 3;

   // Bit positions in the raw key bus
   localparam int unsigned KEY_INC  = 0;
   localparam int unsigned KEY_DEC  = 1;
   localparam int unsigned KEY_CONF = 2;
   localparam int unsigned KEY_CANC = 3;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StSelX   = 3'd1,
      StSelY   = 3'd2,
      StSelZ   = 3'd3,
      StSelCol = 3'd4,
      StCommit = 3'd5
   } sel_state_e;

   // Single winning action after arbitration
   typedef enum logic [2:0] {
      ActNone = 3'd0,
      ActInc  = 3'd1,
      ActDec  = 3'd2,
      ActConf = 3'd3,
      ActCanc = 3'd4
   } sel_act_e;

   // Step a 3-bit field up or down, wrapping mod 8
   function automatic logic [2:0] wrap_step(input logic [2:0] val, input sel_act_e act);
      logic [2:0] res;
      res = val;
      if (act == ActInc) begin
         res = val + 3'd1;
      end else if (act == ActDec) begin
         res = val - 3'd1;
      end
      return res;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: 2-flop synchroniser, debounce filter, press pulse and optional auto-repeat.
module key_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_RATE     = 5000000,
   parameter bit          REPEAT_EN       = 1'b0
) (
   input  logic clk,
   input  logic resetn,
   input  logic i_key_n,
   output logic o_event
);

   localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

   logic           r_sync1;
   logic           r_sync2;
   logic [DbW-1:0] r_db_cnt;
   logic           r_level;
   logic           r_level_d1;
   logic           r_event;
   logic           w_rep_hit;

   // Synchronise and invert to active-high "pressed"
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= ~i_key_n;
         r_sync2 <= r_sync1;
      end
   end

   // Accept a new level only after DEBOUNCE_CYCLES consecutive differing samples
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_db_cnt <= '0;
         r_level  <= 1'b0;
      end else if (r_sync2 == r_level) begin
         r_db_cnt <= '0;
      end else if (r_db_cnt == DbW'(DEBOUNCE_CYCLES - 1)) begin
         r_db_cnt <= '0;
         r_level  <= r_sync2;
      end else begin
         r_db_cnt <= r_db_cnt + DbW'(1);
      end
   end

   // Registered press pulse on accepted rising level, merged with repeat hits
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_level_d1 <= 1'b0;
         r_event    <= 1'b0;
      end else begin
         r_level_d1 <= r_level;
         r_event    <= (r_level & ~r_level_d1) | w_rep_hit;
      end
   end

   if (REPEAT_EN) begin : g_rep
      localparam int unsigned RpW = $clog2(REPEAT_DELAY + 1);
      logic [RpW-1:0] r_rep_cnt;

      // Counter reads k at the k-th edge after the press pulse; reload keeps the RATE period
      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            r_rep_cnt <= '0;
         end else if (!r_level) begin
            r_rep_cnt <= '0;
         end else if (!r_level_d1) begin
            r_rep_cnt <= RpW'(1);
         end else if (r_rep_cnt == RpW'(REPEAT_DELAY)) begin
            r_rep_cnt <= RpW'(REPEAT_DELAY - REPEAT_RATE + 1);
         end else begin
            r_rep_cnt <= r_rep_cnt + RpW'(1);
         end
      end

      assign w_rep_hit = r_level & r_level_d1 & (r_rep_cnt == RpW'(REPEAT_DELAY));
   end else begin : g_norep
      assign w_rep_hit = 1'b0;
   end

   assign o_event = r_event;

endmodule

// File: rtl/select_input_ctrl.sv
// Pushbutton front end: debounced key events drive the X/Y/Z/colour selection FSM.
module select_input_ctrl import select_pkg::*; #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned REPEAT_DELAY    = 25000000,
   parameter int unsigned REPEAT_RATE     = 5000000
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic [3:0]         key,
   output logic               pos,
   output logic               c_col,
   output logic [COORD_W-1:0] x,
   output logic [COORD_W-1:0] y,
   output logic [COORD_W-1:0] z,
   output logic [COLOR_W-1:0] c,
   output logic               commit,
   output logic [2:0]         state_o
);

   logic [3:0]         w_ev;
   sel_act_e           w_act;
   sel_state_e         r_state;
   sel_state_e         w_state_next;
   logic [COORD_W-1:0] r_x, r_y, r_z;
   logic [COORD_W-1:0] w_x_next, w_y_next, w_z_next;
   logic [COLOR_W-1:0] r_c, w_c_next;
   logic               r_pos, r_c_col, r_commit;

   for (genvar gi = 0; gi < 4; gi++) begin : g_key
      key_debounce #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_RATE    (REPEAT_RATE),
         .REPEAT_EN      ((gi == KEY_INC) || (gi == KEY_DEC))
      ) u_key (
         .clk    (clk),
         .resetn (resetn),
         .i_key_n(key[gi]),
         .o_event(w_ev[gi])
      );
   end

   // Fixed-priority pick; losing events in the same cycle are dropped
   always_comb begin
      w_act = ActNone;
      if (w_ev[KEY_CANC]) begin
         w_act = ActCanc;
      end else if (w_ev[KEY_CONF]) begin
         w_act = ActConf;
      end else if (w_ev[KEY_INC]) begin
         w_act = ActInc;
      end else if (w_ev[KEY_DEC]) begin
         w_act = ActDec;
      end
   end

   // Next state and field updates
   always_comb begin
      w_state_next = r_state;
      w_x_next     = r_x;
      w_y_next     = r_y;
      w_z_next     = r_z;
      w_c_next     = r_c;
      unique case (r_state)
         StIdle: begin
            if (w_act == ActConf) w_state_next = StSelX;
         end
         StSelX: begin
            w_x_next = wrap_step(r_x, w_act);
            if (w_act == ActConf) w_state_next = StSelY;
            if (w_act == ActCanc) w_state_next = StIdle;
         end
         StSelY: begin
            w_y_next = wrap_step(r_y, w_act);
            if (w_act == ActConf) w_state_next = StSelZ;
            if (w_act == ActCanc) w_state_next = StSelX;
         end
         StSelZ: begin
            w_z_next = wrap_step(r_z, w_act);
            if (w_act == ActConf) w_state_next = StSelCol;
            if (w_act == ActCanc) w_state_next = StSelY;
         end
         StSelCol: begin
            w_c_next = wrap_step(r_c, w_act);
            if (w_act == ActConf) w_state_next = StCommit;
            if (w_act == ActCanc) w_state_next = StSelZ;
         end
         // Single-cycle strobe; any event seen here is discarded
         StCommit: w_state_next = StSelX;
         default:  w_state_next = StIdle;
      endcase
   end

   // State, fields and state-decoded outputs registered together
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state  <= StIdle;
         r_x      <= '0;
         r_y      <= '0;
         r_z      <= '0;
         r_c      <= '0;
         r_pos    <= 1'b0;
         r_c_col  <= 1'b0;
         r_commit <= 1'b0;
      end else begin
         r_state  <= w_state_next;
         r_x      <= w_x_next;
         r_y      <= w_y_next;
         r_z      <= w_z_next;
         r_c      <= w_c_next;
         r_pos    <= (w_state_next == StSelX) || (w_state_next == StSelY) ||
                     (w_state_next == StSelZ);
         r_c_col  <= (w_state_next == StSelCol);
         r_commit <= (w_state_next == StCommit);
      end
   end

   assign pos     = r_pos;
   assign c_col   = r_c_col;
   assign commit  = r_commit;
   assign x       = r_x;
   assign y       = r_y;
   assign z       = r_z;
   assign c       = r_c;
   assign state_o = r_state;

endmodule

// File: tb/tb_select_input_ctrl.sv
// Directed bench for select_input_ctrl with short debounce/repeat timing.
module tb_select_input_ctrl;

   logic       clk;
   logic       resetn;
   logic [3:0] key;
   logic       pos, c_col, commit;
   logic [2:0] x, y, z, c, state_o;

   int n_checks = 0;
   int n_fail   = 0;

   select_input_ctrl #(
      .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY   (20),
      .REPEAT_RATE    (5)
   ) u_dut (
      .clk    (clk),
      .resetn (resetn),
      .key    (key),
      .pos    (pos),
      .c_col  (c_col),
      .x      (x),
      .y      (y),
      .z      (z),
      .c      (c),
      .commit (commit),
      .state_o(state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the edge
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Clean press: hold 10 cycles, release, wait until the release is debounced
   task automatic press(input int idx);
      key[idx] = 1'b0;
      step(10);
      key[idx] = 1'b1;
      step(8);
   endtask

   task automatic glitch(input int lo, input int hi);
      key[0] = 1'b0;
      step(lo);
      key[0] = 1'b1;
      step(hi);
   endtask

   initial begin
      resetn = 1'b0;
      key    = 4'hF;
      step(2);

      // Reset state
      check("rst_state", state_o, 0);
      check("rst_pos", pos, 0);
      check("rst_ccol", c_col, 0);
      check("rst_fields", {x, y, z, c}, 0);
      check("rst_commit", commit, 0);

      // Confirm from IDLE enters SEL_X
      resetn = 1'b1;
      press(2);
      check("conf_state", state_o, 1);
      check("conf_pos", pos, 1);
      check("conf_ccol", c_col, 0);
      check("conf_fields", {x, y, z, c}, 0);

      // Asynchronous reset mid-press clears immediately
      key[0] = 1'b0;
      step(3);
      resetn = 1'b0;
      #1;
      check("async_rst_state", state_o, 0);
      check("async_rst_pos", pos, 0);
      key[0] = 1'b1;
      key[2] = 1'b0;
      step(2);
      // Confirm held through reset release counts as a fresh, fully debounced press
      resetn = 1'b1;
      step(7);
      check("held_rst_early", state_o, 0);
      step(1);
      check("held_rst_accept", state_o, 1);
      key[2] = 1'b1;
      step(8);
      check("held_rst_x", x, 0);

      // Bouncy inc press: exactly one step, 8-cycle latency
      glitch(1, 1);
      glitch(2, 1);
      glitch(3, 1);
      key[0] = 1'b0;
      step(7);
      check("bounce_pre", x, 0);
      step(1);
      check("bounce_lat", x, 1);
      step(2);
      key[0] = 1'b1;
      step(8);
      check("bounce_once", x, 1);
      glitch(3, 1);
      glitch(3, 1);
      glitch(3, 1);
      step(8);
      check("glitch_only", x, 1);

      // Decrement with wrap
      press(1);
      check("dec", x, 0);
      press(1);
      check("dec_wrap", x, 7);

      // Auto-repeat: press at edge 7, repeats at 27, 32, 37
      key[0] = 1'b0;
      step(8);
      check("rep_first", x, 0);
      step(19);
      check("rep_before_delay", x, 0);
      step(1);
      check("rep_delay", x, 1);
      step(5);
      check("rep_rate", x, 2);
      key[0] = 1'b1;
      step(5);
      check("rep_third", x, 3);
      step(12);
      check("rep_release", x, 3);

      // Set x=2, y=5, z=7
      press(1);
      check("x_set", x, 2);
      press(2);
      check("sel_y", state_o, 2);
      press(1);
      press(1);
      press(1);
      check("y_set", y, 5);
      press(2);
      check("sel_z", state_o, 3);
      press(1);
      check("z_set", z, 7);
      press(2);
      check("sel_col", state_o, 4);
      check("sel_col_ccol", c_col, 1);
      check("sel_col_pos", pos, 0);

      // Colour wraps down, then up to 3
      press(1);
      check("c_wrap", c, 7);
      check("c_wrap_ccol", c_col, 1);
      check("c_wrap_pos", pos, 0);
      press(0);
      press(0);
      press(0);
      press(0);
      check("c_set", c, 3);

      // Commit strobe; inc event landing in the COMMIT cycle is dropped
      key[2] = 1'b0;
      step(1);
      key[0] = 1'b0;
      step(6);
      check("commit_pre", commit, 0);
      step(1);
      check("commit_hi", commit, 1);
      check("commit_state", state_o, 5);
      check("commit_pos", pos, 0);
      check("commit_ccol", c_col, 0);
      check("commit_fields", {x, y, z, c}, {3'd2, 3'd5, 3'd7, 3'd3});
      step(1);
      check("commit_lo", commit, 0);
      check("post_commit_state", state_o, 1);
      check("post_commit_pos", pos, 1);
      check("commit_drop_inc", x, 2);
      step(1);
      key = 4'hF;
      step(10);
      check("post_commit_x", x, 2);
      check("post_commit_fields", {y, z, c}, {3'd5, 3'd7, 3'd3});

      // Cancel beats confirm in SEL_Y
      press(2);
      check("sel_y2", state_o, 2);
      key[2] = 1'b0;
      key[3] = 1'b0;
      step(10);
      key = 4'hF;
      step(8);
      check("canc_wins", state_o, 1);
      check("canc_y_kept", y, 5);

      // Cancel in SEL_X returns to IDLE; inc ignored there
      press(3);
      check("canc_idle", state_o, 0);
      check("canc_idle_pos", pos, 0);
      press(0);
      check("idle_ignore_inc", x, 2);
      check("idle_stays", state_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
